// File: rtl/stochastic_pkg.sv
// Shared types and LFSR helpers for the stochastic job source.
package stochastic_pkg;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_FIX = 32'h1;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_OFFER} state_e;

  // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? LFSR_ZERO_FIX : s;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load; load wins over step.
module lfsr32
  import stochastic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= LFSR_ZERO_FIX;
    else if (load) value <= lfsr_seed_fix(seed);
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/stochastic_job_source.sv
// Seed-controlled (item, weight) job generator with pseudo-random inter-arrival gaps.
module stochastic_job_source
  import stochastic_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4,
  parameter int GAP_W    = 3,
  parameter int MAX_JOBS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load_seeds,
  input  logic [DATA_W-1:0] seed1,
  input  logic [DATA_W-1:0] seed2,
  input  logic [DATA_W-1:0] seed3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_item,
  output logic [DATA_W-1:0] out_weight,
  output logic [DATA_W-1:0] jobs_issued,
  output logic              done
);

  localparam logic [31:0] GAP_MASK = 32'((64'd1 << GAP_W) - 64'd1);

  state_e            state;
  logic [DATA_W-1:0] id;
  logic [31:0]       cnt;
  logic [31:0]       lfsr_w, lfsr_g, lfsr_w_nxt, gap_draw;
  logic [DATA_W-1:0] wt_cur, wt_nxt;
  logic              hs, max_hit, draw_idle, draw_hs, w_step, g_step;

  // out_valid is always high in OFFER, so the handshake reduces to ready.
  assign hs         = (state == ST_OFFER) && out_ready;
  assign max_hit    = (MAX_JOBS != 0) && ((jobs_issued + DATA_W'(1)) == DATA_W'(MAX_JOBS));
  assign draw_idle  = (state == ST_IDLE) && enable && !done;
  assign draw_hs    = hs && !max_hit && enable;
  assign w_step     = !load_seeds && hs;
  assign g_step     = !load_seeds && (draw_idle || draw_hs);
  assign gap_draw   = lfsr_g & GAP_MASK;
  assign lfsr_w_nxt = lfsr_next(lfsr_w);
  assign wt_cur     = DATA_W'(lfsr_w[WEIGHT_W-1:0]) + DATA_W'(1);
  assign wt_nxt     = DATA_W'(lfsr_w_nxt[WEIGHT_W-1:0]) + DATA_W'(1);

  lfsr32 u_lfsr_w (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_seeds),
    .seed  (32'(seed2)),
    .step  (w_step),
    .value (lfsr_w)
  );

  lfsr32 u_lfsr_g (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_seeds),
    .seed  (32'(seed3)),
    .step  (g_step),
    .value (lfsr_g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      id          <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_item    <= '0;
      out_weight  <= '0;
      jobs_issued <= '0;
      done        <= 1'b0;
    end else if (load_seeds) begin
      state       <= ST_IDLE;
      id          <= seed1;
      cnt         <= '0;
      out_valid   <= 1'b0;
      jobs_issued <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !done) begin
            if (gap_draw == 32'h0) begin
              state      <= ST_OFFER;
              out_valid  <= 1'b1;
              out_item   <= id;
              out_weight <= wt_cur;
            end else begin
              state <= ST_GAP;
              cnt   <= gap_draw;
            end
          end
        end
        ST_GAP: begin
          if (enable) begin
            if (cnt <= 32'h1) begin
              state      <= ST_OFFER;
              cnt        <= '0;
              out_valid  <= 1'b1;
              out_item   <= id;
              out_weight <= wt_cur;
            end else begin
              cnt <= cnt - 32'h1;
            end
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            id          <= id + DATA_W'(1);
            jobs_issued <= jobs_issued + DATA_W'(1);
            if (max_hit) begin
              done      <= 1'b1;
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end else if (enable) begin
              if (gap_draw == 32'h0) begin
                // Back-to-back: next job uses the post-step weight LFSR value.
                out_item   <= id + DATA_W'(1);
                out_weight <= wt_nxt;
              end else begin
                out_valid <= 1'b0;
                cnt       <= gap_draw;
                state     <= ST_GAP;
              end
            end else begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
